// File: rtl/hyper_cfg_sequencer.sv
// Boot-time configuration sequencer and register-port arbiter for the HyperBus controller.
// Writes a fixed table of configuration words after startup, then hands the port to software.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | software owns the register port
// DRAIN   | launch pending; waiting for any software transfer to finish
// WAIT    | start delay countdown, port owned by sequencer
// ISSUE   | table write idx_q presented to the controller
// BACKOFF | one idle cycle after an error response before retrying
// DONE    | transit cycle after the last entry succeeded
// FAIL    | transit cycle after an entry ran out of retries
module hyper_cfg_sequencer #(
  parameter int unsigned RegAddrWidth = 32,
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned NumEntries   = 4,
  parameter logic [NumEntries-1:0][RegAddrWidth-1:0] CfgAddrs = '0,
  parameter logic [NumEntries-1:0][RegDataWidth-1:0] CfgData  = '0,
  parameter int unsigned StartDelay   = 16,
  parameter int unsigned MaxRetries   = 3,
  parameter bit          AutoStart    = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        sw_valid_i,
  input  logic [RegAddrWidth-1:0]     sw_addr_i,
  input  logic                        sw_write_i,
  input  logic [RegDataWidth-1:0]     sw_wdata_i,
  input  logic [RegDataWidth/8-1:0]   sw_wstrb_i,
  output logic                        sw_ready_o,
  output logic [RegDataWidth-1:0]     sw_rdata_o,
  output logic                        sw_error_o,
  output logic                        hb_valid_o,
  output logic [RegAddrWidth-1:0]     hb_addr_o,
  output logic                        hb_write_o,
  output logic [RegDataWidth-1:0]     hb_wdata_o,
  output logic [RegDataWidth/8-1:0]   hb_wstrb_o,
  input  logic                        hb_ready_i,
  input  logic [RegDataWidth-1:0]     hb_rdata_i,
  input  logic                        hb_error_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        fail_o,
  output logic [$clog2(NumEntries):0] fail_idx_o
);

  localparam int unsigned IdxW = $clog2(NumEntries) + 1;
  localparam int unsigned SelW = (NumEntries > 1) ? $clog2(NumEntries) : 1;
  localparam int unsigned DlyW = (StartDelay > 1) ? $clog2(StartDelay) : 1;
  localparam int unsigned RtyW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_WAIT, S_ISSUE, S_BACKOFF, S_DONE, S_FAIL
  } state_e;

  state_e          state_q;
  logic            first_q;
  logic [DlyW-1:0] dly_q;
  logic [IdxW-1:0] idx_q;
  logic [RtyW-1:0] retry_q;

  logic            sw_owns;
  logic            last_entry;
  logic            can_retry;
  logic [SelW-1:0] sel;

  assign sw_owns    = (state_q == S_IDLE) || (state_q == S_DRAIN);
  assign sel        = idx_q[SelW-1:0];
  assign last_entry = (idx_q == IdxW'(NumEntries - 1));
  assign can_retry  = (32'(retry_q) < MaxRetries);

  // Ready is qualified with valid so an idle software port never sees a stray accept.
  always_comb begin
    hb_valid_o = 1'b0;
    hb_addr_o  = '0;
    hb_write_o = 1'b0;
    hb_wdata_o = '0;
    hb_wstrb_o = '0;
    sw_ready_o = 1'b0;
    sw_rdata_o = '0;
    sw_error_o = 1'b0;
    if (sw_owns) begin
      hb_valid_o = sw_valid_i;
      hb_addr_o  = sw_addr_i;
      hb_write_o = sw_write_i;
      hb_wdata_o = sw_wdata_i;
      hb_wstrb_o = sw_wstrb_i;
      sw_ready_o = sw_valid_i && hb_ready_i;
      sw_rdata_o = hb_rdata_i;
      sw_error_o = hb_error_i;
    end else if (state_q == S_ISSUE) begin
      hb_valid_o = 1'b1;
      hb_addr_o  = CfgAddrs[sel];
      hb_write_o = 1'b1;
      hb_wdata_o = CfgData[sel];
      hb_wstrb_o = '1;
    end
  end

  // Status flags are updated on the transition into DONE/FAIL so they are visible in that cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      first_q    <= 1'b1;
      dly_q      <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      fail_o     <= 1'b0;
      fail_idx_o <= '0;
    end else begin
      first_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if ((AutoStart && first_q) || start_i) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!sw_valid_i || hb_ready_i) begin
            done_o  <= 1'b0;
            fail_o  <= 1'b0;
            dly_q   <= DlyW'(StartDelay - 1);
            busy_o  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dly_q == '0) begin
            idx_q   <= '0;
            retry_q <= '0;
            state_q <= S_ISSUE;
          end else begin
            dly_q <= dly_q - DlyW'(1);
          end
        end
        S_ISSUE: begin
          if (hb_ready_i) begin
            if (!hb_error_i) begin
              if (last_entry) begin
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                state_q <= S_DONE;
              end else begin
                idx_q   <= idx_q + IdxW'(1);
                retry_q <= '0;
              end
            end else if (can_retry) begin
              retry_q <= retry_q + RtyW'(1);
              state_q <= S_BACKOFF;
            end else begin
              fail_o     <= 1'b1;
              fail_idx_o <= idx_q;
              busy_o     <= 1'b0;
              state_q    <= S_FAIL;
            end
          end
        end
        S_BACKOFF: state_q <= S_ISSUE;
        S_DONE:    state_q <= S_IDLE;
        S_FAIL:    state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

endmodule
